id_ctrl_sequencer: RTL and testbench
====================================

# id_ctrl_sequencer

Registered decode-stage control sequencer for the pipelined MIPS core. It is the successor to the purely combinational main decoder. It decodes opcode/funct into the ID/EX control word and holds that word in a stall/flush-aware pipeline register. It also sequences multi-cycle multiply/divide issue with a busy counter, and runs a HALT drain state machine that idles the pipeline before asserting `o_halted`.

## Interface
- `MUL_LAT`, 4: cycles the multiplier stays busy after a MULT/MULTU start.
- `DIV_LAT`, 32: cycles the divider stays busy after a DIV/DIVU start.
- `DRAIN_CYCLES`, 3: bubbles inserted after HALT before `o_halted`.
- `CNT_W`, 6: width of the busy and drain counters; must satisfy `2^CNT_W > max(DIV_LAT, DRAIN_CYCLES)`.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `i_valid` in 1: the ID-stage instruction is valid.
- `i_op` in 6: opcode field.
- `i_funct` in 6: funct field.
- `i_eq`, `i_gtz`, `i_ltz`, `i_ltez` in 1 each: branch comparator flags.
- `i_stall_ext` in 1: hazard-unit stall; holds the ID/EX register.
- `i_flush` in 1: ID/EX flush; loads a bubble.
- `i_resume` in 1: leave the HALTED state.
- `o_regwrite`, `o_memwrite`, `o_alusrc`, `o_sign_sel` out 1 each: registered control bits.
- `o_memtoreg`, `o_regdst`, `o_ram_sel` out 2 each: registered control fields.
- `o_alu_op`, `o_mem_sel` out 3 each: registered control fields.
- `o_pcsrc` out 1: combinational branch-taken signal.
- `o_pcsel` out 2: combinational PC source select (00 = +4, 01 = rs, 10 = jump target).
- `o_mdu_start` out 1: registered one-cycle MDU start pulse.
- `o_mdu_op` out 2: registered MDU operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU).
- `o_stall_d` out 1: stall request to IF/ID.
- `o_pc_load` out 1: PC register enable.
- `o_halted` out 1: the core is halted.
- `o_illegal` out 1: registered pulse flagging an undefined opcode or funct.

## Operation
- Decode encodings: R-type 000000; LW/LH/LHU/LB/LBU; SW/SH/SB; BEQ/BNE/BLEZ/BGTZ/BLTZ; ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU; J/JAL; HALT 111111. JR and JALR are R-type funct 001000 and 001001.
- Field values:
  - `o_memtoreg`: 01 for loads, 10 for JAL/JALR.
  - `o_regdst`: 01 for R-type, 10 for link.
  - `o_mem_sel`: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU.
  - `o_ram_sel`: 0 SW, 1 SH, 2 SB.
  - `o_alu_op`: 010 R-type, 100 ANDI, 101 ORI, 110 XORI, 011 SLTI/SLTIU.
  - `o_sign_sel` = 1 for SLTIU and ADDIU.
- `o_pcsrc` and `o_pcsel` are combinational and gated by `i_valid & ~o_stall_d` and by the FSM being in RUN.
  - BEQ takes `i_eq`, BNE takes `~i_eq`, BLEZ takes `i_ltez`, BGTZ takes `i_gtz`, BLTZ takes `i_ltz`.
- ID/EX register update priority: `!rst_n` loads zeros; then `i_flush` loads a bubble; then `i_stall_ext` holds; then `o_stall_d` or a non-RUN state loads a bubble; otherwise it loads the decoded word.
- MDU busy counter:
  - Issuing MULT/MULTU (funct 011000/011001) or DIV/DIVU (011010/011011) pulses `o_mdu_start` and loads the counter with `MUL_LAT` or `DIV_LAT`.
  - The counter decrements every cycle while nonzero; busy = counter ≠ 0.
  - While busy, decoding MFHI, MFLO, MULT*, or DIV* asserts `o_stall_d`; other instructions proceed.
- FSM states are RUN, DRAIN and HALTED.
  - RUN → DRAIN when HALT issues (valid, not stalled, not flushed); the drain counter loads `DRAIN_CYCLES`.
  - DRAIN: the drain counter decrements to 0. DRAIN → HALTED once it is 0 and MDU busy = 0.
  - DRAIN → RUN on `i_flush`, because the HALT was on the wrong path.
  - HALTED → RUN on `i_resume`.
- `o_pc_load` = RUN & ~`o_stall_d`. It is 0 in DRAIN and HALTED.
- `o_halted` = (state == HALTED), registered.

## Timing
- Reset: all registered outputs are 0, the FSM is in RUN, and both counters are 0. `o_pc_load` = 1 when `i_valid` = 0.
- Control word latency is 1 cycle from ID decode to the outputs. `o_pcsrc` and `o_pcsel` have 0-cycle latency.
- `o_mdu_start` is high for exactly one cycle. It is suppressed if `i_flush` or `i_stall_ext` is high in the issue cycle, and the counter is then not loaded.
- `o_stall_d` is asserted combinationally in the same cycle. It drops in the cycle the counter reads 0.
- Simultaneous HALT issue and `i_flush`: the flush wins and the FSM stays in RUN.
- `o_illegal` is high for one cycle on an undefined opcode or funct; the register loads a bubble.
- Reset during DRAIN or MDU busy returns to RUN with counters at 0 on the next edge.

## Configuration
- `ID_CTRL_MDU_EN` defined: MULT/MULTU/DIV/DIVU/MFHI/MFLO decode, the busy counter and MDU stalls are active.
- Undefined: those functs decode as illegal (`o_illegal` pulse, bubble). `o_mdu_start` and `o_mdu_op` are tied to 0, and there is no busy counter, so DRAIN ignores MDU busy.

## Test plan
- ADDI then LW: on the following edges the register shows `o_regwrite`=1, `o_alusrc`=1, `o_alu_op`=000, then `o_memtoreg`=01, `o_mem_sel`=0.
- BNE with `i_eq`=0 → `o_pcsrc`=1 in the same cycle. With `i_flush` held, the register stays all zeros.
- DIV (MDU_EN, `DIV_LAT`=32) followed by MFLO → `o_mdu_start` pulses once with `o_mdu_op`=10, `o_stall_d`=1 for 32 cycles, and MFLO issues in cycle 33.
- HALT with `DRAIN_CYCLES`=3 → 3 bubbles with `o_pc_load`=0, then `o_halted`=1. `i_resume` → RUN and `o_pc_load`=1.
- HALT issued together with `i_flush` → stays in RUN with no drain. `rst_n`=0 in the middle of DRAIN → RUN, all outputs 0.
- Without `ID_CTRL_MDU_EN`: funct 011000 → `o_illegal` one-cycle pulse, bubble, `o_mdu_start`=0.

Source files
------------

// File: rtl/id_ctrl_sequencer.sv
// Registered ID/EX control decode with MDU busy sequencing and a HALT drain FSM.
// Build option: define ID_CTRL_MDU_EN to enable MULT/DIV/MFHI/MFLO decode and MDU stalls.
module id_ctrl_sequencer #(
  parameter int unsigned MUL_LAT      = 4,
  parameter int unsigned DIV_LAT      = 32,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_eq,
  input  logic       i_gtz,
  input  logic       i_ltz,
  input  logic       i_ltez,
  input  logic       i_stall_ext,
  input  logic       i_flush,
  input  logic       i_resume,
  output logic       o_regwrite,
  output logic       o_memwrite,
  output logic       o_alusrc,
  output logic       o_sign_sel,
  output logic [1:0] o_memtoreg,
  output logic [1:0] o_regdst,
  output logic [1:0] o_ram_sel,
  output logic [2:0] o_alu_op,
  output logic [2:0] o_mem_sel,
  output logic       o_pcsrc,
  output logic [1:0] o_pcsel,
  output logic       o_mdu_start,
  output logic [1:0] o_mdu_op,
  output logic       o_stall_d,
  output logic       o_pc_load,
  output logic       o_halted,
  output logic       o_illegal
);

  if ((2 ** CNT_W) <= DIV_LAT || (2 ** CNT_W) <= MUL_LAT ||
      (2 ** CNT_W) <= DRAIN_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured latencies");
  end

  localparam logic [5:0] OpRtype  = 6'b000000;
  localparam logic [5:0] OpRegimm = 6'b000001;
  localparam logic [5:0] OpJ      = 6'b000010;
  localparam logic [5:0] OpJal    = 6'b000011;
  localparam logic [5:0] OpBeq    = 6'b000100;
  localparam logic [5:0] OpBne    = 6'b000101;
  localparam logic [5:0] OpBlez   = 6'b000110;
  localparam logic [5:0] OpBgtz   = 6'b000111;
  localparam logic [5:0] OpAddi   = 6'b001000;
  localparam logic [5:0] OpAddiu  = 6'b001001;
  localparam logic [5:0] OpSlti   = 6'b001010;
  localparam logic [5:0] OpSltiu  = 6'b001011;
  localparam logic [5:0] OpAndi   = 6'b001100;
  localparam logic [5:0] OpOri    = 6'b001101;
  localparam logic [5:0] OpXori   = 6'b001110;
  localparam logic [5:0] OpLb     = 6'b100000;
  localparam logic [5:0] OpLh     = 6'b100001;
  localparam logic [5:0] OpLw     = 6'b100011;
  localparam logic [5:0] OpLbu    = 6'b100100;
  localparam logic [5:0] OpLhu    = 6'b100101;
  localparam logic [5:0] OpSb     = 6'b101000;
  localparam logic [5:0] OpSh     = 6'b101001;
  localparam logic [5:0] OpSw     = 6'b101011;
  localparam logic [5:0] OpHalt   = 6'b111111;

  localparam logic [5:0] FnJr     = 6'b001000;
  localparam logic [5:0] FnJalr   = 6'b001001;
`ifdef ID_CTRL_MDU_EN
  localparam logic [5:0] FnMfhi   = 6'b010000;
  localparam logic [5:0] FnMflo   = 6'b010010;
  localparam logic [5:0] FnMult   = 6'b011000;
  localparam logic [5:0] FnMultu  = 6'b011001;
  localparam logic [5:0] FnDiv    = 6'b011010;
  localparam logic [5:0] FnDivu   = 6'b011011;
`endif

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic       sign_sel;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic [1:0] ram_sel;
    logic [2:0] alu_op;
    logic [2:0] mem_sel;
  } ctrl_t;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  ctrl_t            dec_ctrl, ctrl_q, ctrl_d;
  logic [1:0]       dec_pcsel;
  logic             dec_br, dec_halt, dec_illegal;
  logic             run, busy, stall_d, issue, halt_issue;
  logic             illegal_q, illegal_d, halted_q;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
`ifdef ID_CTRL_MDU_EN
  logic             dec_mdu, dec_mdu_dep, mdu_issue;
  logic             mdu_start_q, mdu_start_d;
  logic [1:0]       mdu_op_q, mdu_op_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
`endif

  // Instruction decode; an undefined encoding leaves the word as a bubble.
  always_comb begin
    dec_ctrl    = '0;
    dec_pcsel   = 2'b00;
    dec_br      = 1'b0;
    dec_halt    = 1'b0;
    dec_illegal = 1'b0;
`ifdef ID_CTRL_MDU_EN
    dec_mdu     = 1'b0;
    dec_mdu_dep = 1'b0;
`endif
    case (i_op)
      OpRtype: begin
        case (i_funct)
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011: begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.regdst   = 2'b01;
            dec_ctrl.alu_op   = 3'b010;
          end
          FnJr: dec_pcsel = 2'b01;
          FnJalr: begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.regdst   = 2'b10;
            dec_ctrl.memtoreg = 2'b10;
            dec_pcsel         = 2'b01;
          end
`ifdef ID_CTRL_MDU_EN
          FnMfhi, FnMflo: begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.regdst   = 2'b01;
            dec_ctrl.alu_op   = 3'b010;
            dec_mdu_dep       = 1'b1;
          end
          FnMult, FnMultu, FnDiv, FnDivu: begin
            dec_mdu     = 1'b1;
            dec_mdu_dep = 1'b1;
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      OpLw, OpLh, OpLhu, OpLb, OpLbu: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.memtoreg = 2'b01;
        case (i_op)
          OpLh:    dec_ctrl.mem_sel = 3'd1;
          OpLhu:   dec_ctrl.mem_sel = 3'd2;
          OpLb:    dec_ctrl.mem_sel = 3'd3;
          OpLbu:   dec_ctrl.mem_sel = 3'd4;
          default: dec_ctrl.mem_sel = 3'd0;
        endcase
      end
      OpSw, OpSh, OpSb: begin
        dec_ctrl.memwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        case (i_op)
          OpSh:    dec_ctrl.ram_sel = 2'd1;
          OpSb:    dec_ctrl.ram_sel = 2'd2;
          default: dec_ctrl.ram_sel = 2'd0;
        endcase
      end
      OpBeq:    dec_br = i_eq;
      OpBne:    dec_br = ~i_eq;
      OpBlez:   dec_br = i_ltez;
      OpBgtz:   dec_br = i_gtz;
      OpRegimm: dec_br = i_ltz;
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.sign_sel = (i_op == OpAddiu) || (i_op == OpSltiu);
        case (i_op)
          OpAndi:          dec_ctrl.alu_op = 3'b100;
          OpOri:           dec_ctrl.alu_op = 3'b101;
          OpXori:          dec_ctrl.alu_op = 3'b110;
          OpSlti, OpSltiu: dec_ctrl.alu_op = 3'b011;
          default:         dec_ctrl.alu_op = 3'b000;
        endcase
      end
      OpJ: dec_pcsel = 2'b10;
      OpJal: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.regdst   = 2'b10;
        dec_ctrl.memtoreg = 2'b10;
        dec_pcsel         = 2'b10;
      end
      OpHalt:  dec_halt = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

`ifdef ID_CTRL_MDU_EN
  assign busy    = (busy_cnt_q != '0);
  assign stall_d = i_valid & busy & dec_mdu_dep;
`else
  assign busy    = 1'b0;
  assign stall_d = 1'b0;
`endif

  assign run        = (state_q == StRun);
  assign issue      = i_valid & run & ~stall_d & ~i_flush & ~i_stall_ext;
  assign halt_issue = issue & dec_halt;

  // ID/EX register: flush beats hold beats bubble beats the decoded word.
  always_comb begin
    ctrl_d = ctrl_q;
    if (i_flush) begin
      ctrl_d = '0;
    end else if (i_stall_ext) begin
      ctrl_d = ctrl_q;
    end else if (stall_d || !run || !i_valid) begin
      ctrl_d = '0;
    end else begin
      ctrl_d = dec_ctrl;
    end
  end

  assign illegal_d = issue & dec_illegal;

  always_comb begin
    drain_cnt_d = drain_cnt_q;
    if (halt_issue) begin
      drain_cnt_d = CNT_W'(DRAIN_CYCLES);
    end else if (state_q == StDrain) begin
      if (i_flush || drain_cnt_q == '0) begin
        drain_cnt_d = '0;
      end else begin
        drain_cnt_d = drain_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= (state_d == StHalted);
    end
  end

`ifdef ID_CTRL_MDU_EN
  assign mdu_issue   = issue & dec_mdu;
  assign mdu_start_d = mdu_issue;
  assign mdu_op_d    = mdu_issue ? i_funct[1:0] : mdu_op_q;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (mdu_issue) begin
      busy_cnt_d = i_funct[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdu_start_q <= 1'b0;
      mdu_op_q    <= 2'b00;
      busy_cnt_q  <= '0;
    end else begin
      mdu_start_q <= mdu_start_d;
      mdu_op_q    <= mdu_op_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign o_mdu_start = mdu_start_q;
  assign o_mdu_op    = mdu_op_q;
`else
  assign o_mdu_start = 1'b0;
  assign o_mdu_op    = 2'b00;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; DRAIN exits once the bubble count is spent and the MDU is idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (halt_issue) state_d = StDrain;
      end
      StDrain: begin
        if (i_flush) begin
          state_d = StRun;
        end else if (drain_cnt_d == '0 && !busy) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (i_resume) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_pc_load = run & ~stall_d;
    o_pcsrc   = 1'b0;
    o_pcsel   = 2'b00;
    if (i_valid && !stall_d && run) begin
      o_pcsrc = dec_br;
      o_pcsel = dec_pcsel;
    end
  end

  assign o_stall_d  = stall_d;
  assign o_halted   = halted_q;
  assign o_illegal  = illegal_q;
  assign o_regwrite = ctrl_q.regwrite;
  assign o_memwrite = ctrl_q.memwrite;
  assign o_alusrc   = ctrl_q.alusrc;
  assign o_sign_sel = ctrl_q.sign_sel;
  assign o_memtoreg = ctrl_q.memtoreg;
  assign o_regdst   = ctrl_q.regdst;
  assign o_ram_sel  = ctrl_q.ram_sel;
  assign o_alu_op   = ctrl_q.alu_op;
  assign o_mem_sel  = ctrl_q.mem_sel;

endmodule

// File: tb/tb_id_ctrl_sequencer.sv
// Directed self-checking bench for id_ctrl_sequencer; follows ID_CTRL_MDU_EN like the RTL.
module tb_id_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid, i_eq, i_gtz, i_ltz, i_ltez, i_stall_ext, i_flush, i_resume;
  logic [5:0] i_op, i_funct;
  logic       o_regwrite, o_memwrite, o_alusrc, o_sign_sel;
  logic [1:0] o_memtoreg, o_regdst, o_ram_sel;
  logic [2:0] o_alu_op, o_mem_sel;
  logic       o_pcsrc, o_mdu_start, o_stall_d, o_pc_load, o_halted, o_illegal;
  logic [1:0] o_pcsel, o_mdu_op;

  int n_checks = 0;
  int n_fail   = 0;

  id_ctrl_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_op       (i_op),
    .i_funct    (i_funct),
    .i_eq       (i_eq),
    .i_gtz      (i_gtz),
    .i_ltz      (i_ltz),
    .i_ltez     (i_ltez),
    .i_stall_ext(i_stall_ext),
    .i_flush    (i_flush),
    .i_resume   (i_resume),
    .o_regwrite (o_regwrite),
    .o_memwrite (o_memwrite),
    .o_alusrc   (o_alusrc),
    .o_sign_sel (o_sign_sel),
    .o_memtoreg (o_memtoreg),
    .o_regdst   (o_regdst),
    .o_ram_sel  (o_ram_sel),
    .o_alu_op   (o_alu_op),
    .o_mem_sel  (o_mem_sel),
    .o_pcsrc    (o_pcsrc),
    .o_pcsel    (o_pcsel),
    .o_mdu_start(o_mdu_start),
    .o_mdu_op   (o_mdu_op),
    .o_stall_d  (o_stall_d),
    .o_pc_load  (o_pc_load),
    .o_halted   (o_halted),
    .o_illegal  (o_illegal)
  );

  always #5 clk = ~clk;

  // {regwrite, memwrite, alusrc, sign_sel, memtoreg, regdst, ram_sel, alu_op, mem_sel}
  logic [16:0] ctrl_w;
  assign ctrl_w = {o_regwrite, o_memwrite, o_alusrc, o_sign_sel, o_memtoreg, o_regdst,
                   o_ram_sel, o_alu_op, o_mem_sel};

  function automatic logic [16:0] cw(input logic rw, input logic mw, input logic as,
                                     input logic ss, input logic [1:0] m2r,
                                     input logic [1:0] rd, input logic [1:0] rs,
                                     input logic [2:0] alu, input logic [2:0] ms);
    return {rw, mw, as, ss, m2r, rd, rs, alu, ms};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn);
    i_valid = 1'b1;
    i_op    = op;
    i_funct = fn;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_op    = 6'd0;
    i_funct = 6'd0;
  endtask

  int stall_cycles;
  int extra_starts;

  initial begin
    rst_n = 1'b0; i_eq = 0; i_gtz = 0; i_ltz = 0; i_ltez = 0;
    i_stall_ext = 0; i_flush = 0; i_resume = 0;
    idle();
    step(); step();
    check_eq("rst_ctrl", ctrl_w, 17'd0);
    check_eq("rst_halted", o_halted, 0);
    check_eq("rst_illegal", o_illegal, 0);
    check_eq("rst_mdu", {o_mdu_start, o_mdu_op}, 0);
    check_eq("rst_pc_load", o_pc_load, 1);
    check_eq("rst_stall", o_stall_d, 0);
    rst_n = 1'b1;
    step();

    // ADDI then LW
    drive(6'b001000, 6'd0); step();
    check_eq("addi", ctrl_w, cw(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'd0));
    drive(6'b100011, 6'd0); step();
    check_eq("lw", ctrl_w, cw(1, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'd0));
    drive(6'b001101, 6'd0); step();
    check_eq("ori", ctrl_w, cw(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b101, 3'd0));
    drive(6'b001011, 6'd0); step();
    check_eq("sltiu", ctrl_w, cw(1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b011, 3'd0));
    drive(6'b101000, 6'd0); step();
    check_eq("sb", ctrl_w, cw(0, 1, 1, 0, 2'b00, 2'b00, 2'b10, 3'b000, 3'd0));
    drive(6'b100100, 6'd0); step();
    check_eq("lbu", ctrl_w, cw(1, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'd4));
    drive(6'b000000, 6'b100000); step();
    check_eq("add", ctrl_w, cw(1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b010, 3'd0));

    // Jumps: PC select is combinational, link fields registered
    drive(6'b000011, 6'd0); #1;
    check_eq("jal_pcsel", o_pcsel, 2'b10);
    step();
    check_eq("jal", ctrl_w, cw(1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 3'b000, 3'd0));
    drive(6'b000000, 6'b001000); #1;
    check_eq("jr_pcsel", o_pcsel, 2'b01);
    step();
    check_eq("jr", ctrl_w, 17'd0);

    // Branches
    drive(6'b000101, 6'd0); i_eq = 0; #1;
    check_eq("bne_taken", o_pcsrc, 1);
    i_eq = 1; #1;
    check_eq("bne_not_taken", o_pcsrc, 0);
    i_valid = 0; i_eq = 0; #1;
    check_eq("bne_invalid", o_pcsrc, 0);
    drive(6'b000110, 6'd0); i_ltez = 1; #1;
    check_eq("blez_taken", o_pcsrc, 1);
    i_ltez = 0;

    // Flush held clears the register, external stall holds it
    drive(6'b001000, 6'd0); i_flush = 1; step();
    check_eq("flush1", ctrl_w, 17'd0);
    drive(6'b100011, 6'd0); step();
    check_eq("flush2", ctrl_w, 17'd0);
    i_flush = 0;
    drive(6'b001000, 6'd0); step();
    drive(6'b100011, 6'd0); i_stall_ext = 1; step();
    check_eq("stall_ext_hold", ctrl_w, cw(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'd0));
    i_stall_ext = 0;

    // Undefined opcode
    drive(6'b010000, 6'd0); step();
    check_eq("illegal_op", o_illegal, 1);
    check_eq("illegal_op_bubble", ctrl_w, 17'd0);
    idle(); step();
    check_eq("illegal_op_pulse", o_illegal, 0);

`ifdef ID_CTRL_MDU_EN
    drive(6'b000000, 6'b011010); step();
    check_eq("div_start", o_mdu_start, 1);
    check_eq("div_op", o_mdu_op, 2'b10);
    drive(6'b000000, 6'b010010); #1;
    stall_cycles = 0;
    extra_starts = 0;
    while (o_stall_d && stall_cycles < 100) begin
      if (o_pc_load) extra_starts++;
      step();
      stall_cycles++;
      if (o_mdu_start) extra_starts++;
    end
    check_eq("div_stall_cycles", stall_cycles, 32);
    check_eq("div_single_pulse", extra_starts, 0);
    step();
    check_eq("mflo_issue", ctrl_w, cw(1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b010, 3'd0));
    drive(6'b000000, 6'b011000); step();
    check_eq("mult_op", {o_mdu_start, o_mdu_op}, 3'b100);
    drive(6'b001000, 6'd0); #1;
    check_eq("busy_addi_nostall", o_stall_d, 0);
    idle(); repeat (6) step();
    drive(6'b000000, 6'b011011); i_flush = 1; step();
    check_eq("flush_no_start", o_mdu_start, 0);
    i_flush = 0;
    drive(6'b000000, 6'b010000); #1;
    check_eq("flush_no_busy", o_stall_d, 0);
    idle(); step();
`else
    drive(6'b000000, 6'b011000); step();
    check_eq("mult_illegal", o_illegal, 1);
    check_eq("mult_bubble", ctrl_w, 17'd0);
    check_eq("mult_no_start", o_mdu_start, 0);
    idle(); step();
    check_eq("mult_illegal_pulse", o_illegal, 0);
`endif

    // HALT drain: three bubbles with PC frozen, then halted
    drive(6'b111111, 6'd0); step();
    drive(6'b000101, 6'd0); i_eq = 0; #1;
    check_eq("drain_pcsrc_gated", o_pcsrc, 0);
    idle();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("drain%0d_pc_load", k), o_pc_load, 0);
      check_eq($sformatf("drain%0d_halted", k), o_halted, 0);
      step();
    end
    check_eq("halted", o_halted, 1);
    check_eq("halted_pc_load", o_pc_load, 0);
    check_eq("halted_ctrl", ctrl_w, 17'd0);
    i_resume = 1; step(); i_resume = 0;
    check_eq("resume_halted", o_halted, 0);
    check_eq("resume_pc_load", o_pc_load, 1);

    // HALT together with flush: no drain
    drive(6'b111111, 6'd0); i_flush = 1; step();
    i_flush = 0; idle(); #1;
    check_eq("halt_flush_pc_load", o_pc_load, 1);
    repeat (5) step();
    check_eq("halt_flush_halted", o_halted, 0);

    // Flush during DRAIN returns to RUN
    drive(6'b111111, 6'd0); step();
    idle(); i_flush = 1; step(); i_flush = 0;
    check_eq("drain_flush_pc_load", o_pc_load, 1);
    repeat (5) step();
    check_eq("drain_flush_halted", o_halted, 0);

    // Reset in the middle of DRAIN
    drive(6'b111111, 6'd0); step();
    idle(); step();
    check_eq("pre_rst_drain", o_pc_load, 0);
    rst_n = 0; step();
    check_eq("mid_rst_pc_load", o_pc_load, 1);
    check_eq("mid_rst_halted", o_halted, 0);
    check_eq("mid_rst_ctrl", ctrl_w, 17'd0);
    rst_n = 1;
    repeat (5) step();
    check_eq("post_rst_halted", o_halted, 0);
    check_eq("post_rst_pc_load", o_pc_load, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
